// File: rtl/icw_sequencer.sv
// icw_sequencer: steps ICW1..ICW4 initialization, holds config, decodes OCW1-3 once ready.
// Latency: registered outputs and pulses appear one cycle after the accepting write edge.
// Backpressure: none; every write_strobe is processed, back-to-back writes allowed.
// Optional feature: define ICW_SEQUENCE_ERROR_EN to build the sticky sequence_error register.
module icw_sequencer #(
    parameter int CASCADE_WIDTH  = 8,
    parameter int SLAVE_ID_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      write_strobe,
    input  logic                      address_0,
    input  logic [7:0]                internal_data_bus,
    output logic [2:0]                init_state,
    output logic                      init_done,
    output logic [4:0]                interrupt_vector_address,
    output logic [2:0]                call_address,
    output logic                      level_or_edge_triggered_config,
    output logic                      call_address_interval_4_or_8_config,
    output logic                      single_or_cascade_config,
    output logic                      set_icw4_config,
    output logic [CASCADE_WIDTH-1:0]  cascade_device_config,
    output logic [SLAVE_ID_WIDTH-1:0] slave_id,
    output logic                      u8086_or_mcs80_config,
    output logic                      auto_eoi_config,
    output logic                      buffered_master_or_slave_config,
    output logic                      buffered_mode_config,
    output logic                      special_fully_nest_config,
    output logic                      clear_mask_pulse,
    output logic                      write_ocw1,
    output logic                      write_ocw2,
    output logic                      write_ocw3,
    output logic                      sequence_error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [4:0]                vector_q, vector_d;
    logic [2:0]                call_q, call_d;
    logic [3:0]                icw1_low_q, icw1_low_d;   // {LTIM, ADI, SNGL, IC4}
    logic [CASCADE_WIDTH-1:0]  cascade_q, cascade_d;
    logic [SLAVE_ID_WIDTH-1:0] sid_q, sid_d;
    logic [4:0]                icw4_q, icw4_d;
    logic                      clr_q, clr_d;
    logic                      ocw1_q, ocw1_d;
    logic                      ocw2_q, ocw2_d;
    logic                      ocw3_q, ocw3_d;
    logic                      is_icw1;
    logic                      err_event;

    // ICW1 is recognised in every state and always restarts the sequence
    assign is_icw1 = write_strobe && !address_0 && internal_data_bus[4];

    // Next-state, register capture and pulse generation
    always_comb begin
        state_d    = state_q;
        vector_d   = vector_q;
        call_d     = call_q;
        icw1_low_d = icw1_low_q;
        cascade_d  = cascade_q;
        sid_d      = sid_q;
        icw4_d     = icw4_q;
        clr_d      = 1'b0;
        ocw1_d     = 1'b0;
        ocw2_d     = 1'b0;
        ocw3_d     = 1'b0;
        err_event  = 1'b0;
        if (is_icw1) begin
            call_d     = internal_data_bus[7:5];
            icw1_low_d = internal_data_bus[3:0];
            clr_d      = 1'b1;
            if (!internal_data_bus[0]) icw4_d = 5'd0;
            state_d    = WAIT_ICW2;
        end else if (write_strobe) begin
            case (state_q)
                IDLE: err_event = address_0;
                WAIT_ICW2: begin
                    if (address_0) begin
                        vector_d = internal_data_bus[7:3];
                        if (!icw1_low_q[1])     state_d = WAIT_ICW3;
                        else if (icw1_low_q[0]) state_d = WAIT_ICW4;
                        else                    state_d = READY;
                    end else begin
                        err_event = 1'b1;
                    end
                end
                WAIT_ICW3: begin
                    if (address_0) begin
                        cascade_d = internal_data_bus[CASCADE_WIDTH-1:0];
                        sid_d     = internal_data_bus[SLAVE_ID_WIDTH-1:0];
                        state_d   = icw1_low_q[0] ? WAIT_ICW4 : READY;
                    end else begin
                        err_event = 1'b1;
                    end
                end
                WAIT_ICW4: begin
                    if (address_0) begin
                        icw4_d  = internal_data_bus[4:0];
                        state_d = READY;
                    end else begin
                        err_event = 1'b1;
                    end
                end
                READY: begin
                    if (address_0)                         ocw1_d = 1'b1;
                    else if (!internal_data_bus[3])        ocw2_d = 1'b1;
                    else                                   ocw3_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and configuration registers; reset wins over a coincident write
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            vector_q   <= '0;
            call_q     <= '0;
            icw1_low_q <= '0;
            cascade_q  <= '0;
            sid_q      <= '0;
            icw4_q     <= '0;
            clr_q      <= 1'b0;
            ocw1_q     <= 1'b0;
            ocw2_q     <= 1'b0;
            ocw3_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vector_q   <= vector_d;
            call_q     <= call_d;
            icw1_low_q <= icw1_low_d;
            cascade_q  <= cascade_d;
            sid_q      <= sid_d;
            icw4_q     <= icw4_d;
            clr_q      <= clr_d;
            ocw1_q     <= ocw1_d;
            ocw2_q     <= ocw2_d;
            ocw3_q     <= ocw3_d;
        end
    end

`ifdef ICW_SEQUENCE_ERROR_EN
    logic err_q, err_d;

    // Sticky error: set on a protocol violation, cleared by an accepted ICW1
    always_comb begin
        err_d = err_q;
        if (is_icw1)        err_d = 1'b0;
        else if (err_event) err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign sequence_error = err_q;
`else
    logic unused_err;
    assign unused_err     = err_event;
    assign sequence_error = 1'b0;
`endif

    assign init_state                          = state_q;
    assign init_done                           = (state_q == READY);
    assign interrupt_vector_address            = vector_q;
    assign call_address                        = call_q;
    assign level_or_edge_triggered_config      = icw1_low_q[3];
    assign call_address_interval_4_or_8_config = icw1_low_q[2];
    assign single_or_cascade_config            = icw1_low_q[1];
    assign set_icw4_config                     = icw1_low_q[0];
    assign cascade_device_config               = cascade_q;
    assign slave_id                            = sid_q;
    assign u8086_or_mcs80_config               = icw4_q[0];
    assign auto_eoi_config                     = icw4_q[1];
    assign buffered_master_or_slave_config     = icw4_q[2];
    assign buffered_mode_config                = icw4_q[3];
    assign special_fully_nest_config           = icw4_q[4];
    assign clear_mask_pulse                    = clr_q;
    assign write_ocw1                          = ocw1_q;
    assign write_ocw2                          = ocw2_q;
    assign write_ocw3                          = ocw3_q;

endmodule

// File: tb/tb_icw_sequencer.sv
// tb_icw_sequencer: directed checks of the ICW sequence, OCW decode, restart, reset and error flag.
// Latency: inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: not applicable; the bench issues writes freely.
module tb_icw_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       write_strobe = 1'b0;
    logic       address_0 = 1'b0;
    logic [7:0] internal_data_bus = 8'h00;
    logic [2:0] init_state;
    logic       init_done;
    logic [4:0] interrupt_vector_address;
    logic [2:0] call_address;
    logic       level_cfg, adi_cfg, single_cfg, ic4_cfg;
    logic [7:0] cascade_device_config;
    logic [2:0] slave_id;
    logic       u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg;
    logic       clear_mask_pulse, write_ocw1, write_ocw2, write_ocw3, sequence_error;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    icw_sequencer #(.CASCADE_WIDTH(8), .SLAVE_ID_WIDTH(3)) dut (
        .clock(clock), .reset(reset), .write_strobe(write_strobe),
        .address_0(address_0), .internal_data_bus(internal_data_bus),
        .init_state(init_state), .init_done(init_done),
        .interrupt_vector_address(interrupt_vector_address),
        .call_address(call_address),
        .level_or_edge_triggered_config(level_cfg),
        .call_address_interval_4_or_8_config(adi_cfg),
        .single_or_cascade_config(single_cfg),
        .set_icw4_config(ic4_cfg),
        .cascade_device_config(cascade_device_config),
        .slave_id(slave_id),
        .u8086_or_mcs80_config(u8086_cfg),
        .auto_eoi_config(aeoi_cfg),
        .buffered_master_or_slave_config(bms_cfg),
        .buffered_mode_config(buf_cfg),
        .special_fully_nest_config(sfnm_cfg),
        .clear_mask_pulse(clear_mask_pulse),
        .write_ocw1(write_ocw1), .write_ocw2(write_ocw2), .write_ocw3(write_ocw3),
        .sequence_error(sequence_error)
    );

    // One write; returns on the falling edge after the accepting edge
    task automatic wr(input logic a0, input logic [7:0] d);
        @(negedge clock);
        write_strobe = 1'b1; address_0 = a0; internal_data_bus = d;
        @(negedge clock);
        write_strobe = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({init_state, init_done, interrupt_vector_address, call_address} !== 12'h000) begin
            errors++; $display("FAIL reset_state got %h want 000", {init_state, init_done, interrupt_vector_address, call_address});
        end
        checks++;
        if ({level_cfg, adi_cfg, single_cfg, ic4_cfg, cascade_device_config, slave_id,
             u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg,
             clear_mask_pulse, write_ocw1, write_ocw2, write_ocw3, sequence_error} !== 25'h0) begin
            errors++; $display("FAIL reset_outputs got nonzero, want all 0");
        end
    endtask

    task automatic test_single_no_icw4();
        do_reset();
        wr(1'b0, 8'h1A);
        checks++;
        if ({init_state, clear_mask_pulse, level_cfg, single_cfg, ic4_cfg} !== {3'd1, 4'b1110}) begin
            errors++; $display("FAIL icw1_single got st=%0d clr=%b lvl=%b sngl=%b ic4=%b want 1 1 1 1 0",
                               init_state, clear_mask_pulse, level_cfg, single_cfg, ic4_cfg);
        end
        wr(1'b1, 8'h48);
        checks++;
        if ({init_state, init_done, interrupt_vector_address, clear_mask_pulse} !== {3'd4, 1'b1, 5'h09, 1'b0}) begin
            errors++; $display("FAIL icw2_single got st=%0d done=%b vec=%h clr=%b want 4 1 09 0",
                               init_state, init_done, interrupt_vector_address, clear_mask_pulse);
        end
        checks++;
        if ({u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg} !== 5'b0) begin
            errors++; $display("FAIL icw4_zero got %b want 00000", {u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg});
        end
    endtask

    task automatic test_cascade_icw4();
        do_reset();
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        checks++;
        if ({init_state, interrupt_vector_address} !== {3'd2, 5'h04}) begin
            errors++; $display("FAIL casc_icw2 got st=%0d vec=%h want 2 04", init_state, interrupt_vector_address);
        end
        wr(1'b1, 8'h0F);
        checks++;
        if ({init_state, cascade_device_config, slave_id} !== {3'd3, 8'h0F, 3'd7}) begin
            errors++; $display("FAIL casc_icw3 got st=%0d cas=%h sid=%0d want 3 0f 7", init_state, cascade_device_config, slave_id);
        end
        wr(1'b1, 8'h1F);
        checks++;
        if ({init_state, init_done, u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg} !== {3'd4, 6'b111111}) begin
            errors++; $display("FAIL casc_icw4 got st=%0d done=%b icw4=%b want 4 1 11111",
                               init_state, init_done, {u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg});
        end
    endtask

    task automatic test_ready_decode();
        wr(1'b1, 8'h55);
        checks++;
        if ({write_ocw1, write_ocw2, write_ocw3} !== 3'b100) begin
            errors++; $display("FAIL ocw1 got %b want 100", {write_ocw1, write_ocw2, write_ocw3});
        end
        wr(1'b0, 8'h20);
        checks++;
        if ({write_ocw1, write_ocw2, write_ocw3} !== 3'b010) begin
            errors++; $display("FAIL ocw2 got %b want 010", {write_ocw1, write_ocw2, write_ocw3});
        end
        wr(1'b0, 8'h0B);
        checks++;
        if ({write_ocw1, write_ocw2, write_ocw3} !== 3'b001) begin
            errors++; $display("FAIL ocw3 got %b want 001", {write_ocw1, write_ocw2, write_ocw3});
        end
        idle_cycle();
        checks++;
        if ({write_ocw1, write_ocw2, write_ocw3, init_state, interrupt_vector_address, cascade_device_config}
            !== {3'b000, 3'd4, 5'h04, 8'h0F}) begin
            errors++; $display("FAIL ocw_cfg_kept got ocw=%b st=%0d vec=%h cas=%h want 000 4 04 0f",
                               {write_ocw1, write_ocw2, write_ocw3}, init_state, interrupt_vector_address, cascade_device_config);
        end
    endtask

    task automatic test_restart();
        // ICW4 bits are all 1 from the cascade test; IC4=1 restart keeps them
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        wr(1'b0, 8'h13);
        checks++;
        if ({init_state, single_cfg, clear_mask_pulse, u8086_cfg, sfnm_cfg} !== {3'd1, 4'b1111}) begin
            errors++; $display("FAIL restart_ic4 got st=%0d sngl=%b clr=%b u86=%b sfnm=%b want 1 1 1 1 1",
                               init_state, single_cfg, clear_mask_pulse, u8086_cfg, sfnm_cfg);
        end
        wr(1'b0, 8'h12);
        checks++;
        if ({init_state, ic4_cfg, clear_mask_pulse, u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg} !== {3'd1, 7'b0100000}) begin
            errors++; $display("FAIL restart_noic4 got st=%0d ic4=%b clr=%b icw4=%b want 1 0 1 00000",
                               init_state, ic4_cfg, clear_mask_pulse, {u8086_cfg, aeoi_cfg, bms_cfg, buf_cfg, sfnm_cfg});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clock);
        write_strobe = 1'b1; address_0 = 1'b0; internal_data_bus = 8'h1A;
        @(negedge clock);
        address_0 = 1'b1; internal_data_bus = 8'h48;
        checks++;
        if ({init_state, clear_mask_pulse} !== {3'd1, 1'b1}) begin
            errors++; $display("FAIL b2b_first got st=%0d clr=%b want 1 1", init_state, clear_mask_pulse);
        end
        @(negedge clock);
        address_0 = 1'b1; internal_data_bus = 8'hAA;
        checks++;
        if ({init_state, clear_mask_pulse, interrupt_vector_address} !== {3'd4, 1'b0, 5'h09}) begin
            errors++; $display("FAIL b2b_second got st=%0d clr=%b vec=%h want 4 0 09", init_state, clear_mask_pulse, interrupt_vector_address);
        end
        @(negedge clock);
        write_strobe = 1'b0;
        checks++;
        if (write_ocw1 !== 1'b1) begin
            errors++; $display("FAIL b2b_ocw1 got %b want 1", write_ocw1);
        end
    endtask

    task automatic test_reset_mid_sequence();
        do_reset();
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        @(negedge clock);
        reset = 1'b1; write_strobe = 1'b1; address_0 = 1'b1; internal_data_bus = 8'hFF;
        @(negedge clock);
        reset = 1'b0; write_strobe = 1'b0;
        checks++;
        if ({init_state, init_done, interrupt_vector_address, call_address, cascade_device_config, slave_id,
             single_cfg, ic4_cfg, clear_mask_pulse, write_ocw1} !== 27'h0) begin
            errors++; $display("FAIL reset_mid got st=%0d vec=%h cas=%h sid=%0d ic4=%b want all 0",
                               init_state, interrupt_vector_address, cascade_device_config, slave_id, ic4_cfg);
        end
    endtask

    task automatic test_sequence_error();
        logic exp_err;
`ifdef ICW_SEQUENCE_ERROR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        wr(1'b1, 8'h00);
        checks++;
        if ({sequence_error, init_state} !== {exp_err, 3'd0}) begin
            errors++; $display("FAIL err_idle got err=%b st=%0d want %b 0", sequence_error, init_state, exp_err);
        end
        wr(1'b1, 8'h55);
        idle_cycle();
        checks++;
        if (sequence_error !== exp_err) begin
            errors++; $display("FAIL err_sticky got %b want %b", sequence_error, exp_err);
        end
        wr(1'b0, 8'h13);
        checks++;
        if ({sequence_error, init_state} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL err_clear got err=%b st=%0d want 0 1", sequence_error, init_state);
        end
        wr(1'b0, 8'h05);
        checks++;
        if ({sequence_error, init_state, write_ocw2} !== {exp_err, 3'd1, 1'b0}) begin
            errors++; $display("FAIL err_wait got err=%b st=%0d ocw2=%b want %b 1 0", sequence_error, init_state, write_ocw2, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_no_icw4();
        test_cascade_icw4();
        test_ready_decode();
        test_restart();
        test_back_to_back();
        test_reset_mid_sequence();
        test_sequence_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
